seq_mod_reducer: RTL

- Parametrised, iterative reducer that computes R = X mod M for a wide operand X.
- Generalises the fixed 400-bit / mod-107 combinational reducers: operand width, modulus and digit width are parameters.
- Processes K bits per clock with MSB-first Horner recurrence, behind a valid/ready handshake.
- Sits between the operand source and downstream residue consumers; trades area for multi-cycle latency.

---
 rtl/seq_mod_reducer_if.sv | 23 ++
 rtl/seq_mod_reducer.sv | 100 ++++++++++
 2 files changed

// File: rtl/seq_mod_reducer_if.sv
// Operand/result handshake bundle for seq_mod_reducer.
// The master drives operands and accepts results; the slave is the reducer.
interface seq_mod_reducer_if #(
   parameter int N  = 400,
   parameter int RW = 7
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  X;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] R;

   modport master (
      output in_valid, X, out_ready,
      input  in_ready, out_valid, R
   );

   modport slave (
      input  in_valid, X, out_ready,
      output in_ready, out_valid, R
   );
endinterface

// File: rtl/seq_mod_reducer.sv
// Iterative X mod M reducer: K operand bits per clock, MSB-first Horner recurrence,
// one residue per S+2 clocks behind a valid/ready handshake.
module seq_mod_reducer #(
   parameter int N = 400,
   parameter int M = 107,
   parameter int K = 8
) (
   input logic           clk,
   input logic           rst_n,
   input logic           clr,
   seq_mod_reducer_if.slave bus
);

   localparam int RW = $clog2(M);
   localparam int S  = (N + K - 1) / K;
   localparam int SW = S * K;
   localparam int CW = (S > 1) ? $clog2(S) : 1;
   localparam logic [RW:0] MT = (RW + 1)'(M);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [SW-1:0] sreg;
   logic [RW-1:0] r;
   logic [RW-1:0] r_next;
   logic [RW-1:0] res;
   logic [CW-1:0] cnt;
   logic [K-1:0]  digit;
   logic [RW:0]   t;

   // Horner digit step: each bit doubles the residue and folds it back below M
   // with a single conditional subtract, so r < M holds after every bit.
   always_comb begin
      digit  = sreg[SW-1 -: K];
      r_next = r;
      t      = '0;
      // NOTE: blocking assignments here chain the K bit steps within one cycle;
      // each iteration must see the residue produced by the previous one.
      for (int i = K - 1; i >= 0; i--) begin
         t      = {r_next, digit[i]};
         r_next = (t >= MT) ? RW'(t - MT) : t[RW-1:0];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_n and no latch is inferred.
      state_n = state;
      unique case (state)
         IDLE:    if (bus.in_valid)  state_n = RUN;
         RUN:     if (cnt == '0)     state_n = DONE;
         DONE:    if (bus.out_ready) state_n = IDLE;
         default:                    state_n = IDLE;
      endcase
      // Abort wins over everything, including a same-edge accept.
      if (clr) state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         r    <= '0;
         cnt  <= '0;
         res  <= '0;
      end else if (!clr) begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  // Zero-extension at the MSB end only adds leading zero digits.
                  sreg <= SW'(bus.X);
                  r    <= '0;
                  cnt  <= CW'(S - 1);
               end
            end
            RUN: begin
               sreg <= sreg << K;
               r    <= r_next;
               if (cnt == '0) res <= r_next;
               else           cnt <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.R         = res;

endmodule
